// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. The input is oversampled 16x from a
//                fractional phase accumulator. Each received byte is presented
//                on a valid/ready interface, and framing and overrun errors
//                are reported as single-clock pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int ACC_W   = 20,
  parameter int OVS_INC = 19328,
  parameter int DATA_W  = 8
) (
  input  logic              clock100,
  input  logic              reset_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_overrun
);

  localparam int c_IDX_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic               r_sync1, r_sync2;
  logic [ACC_W-1:0]   r_acc;
  state_t             r_state, w_state_nxt;
  logic [3:0]         r_tick_cnt, w_cnt_nxt;
  logic [c_IDX_W-1:0] r_bit_idx, w_idx_nxt;
  logic [DATA_W-1:0]  r_shreg, w_shreg_nxt;
  logic               r_deliver;
  logic               w_stop_ok, w_stop_bad;
  logic [ACC_W:0]     w_sum;
  logic               w_tick;
  logic               w_rxs;

  assign w_rxs  = r_sync2;
  assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(OVS_INC);
  assign w_tick = w_sum[ACC_W];

  // Synchroniser presets to the idle level so reset never looks like a start bit
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_acc   <= '0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_acc   <= w_sum[ACC_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_tick_cnt;
    w_idx_nxt   = r_bit_idx;
    w_shreg_nxt = r_shreg;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = 4'd0;
          end
        end
        S_START: begin
          w_cnt_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd7) begin
            if (w_rxs) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = 4'd0;
              w_idx_nxt   = '0;
            end
          end
        end
        S_DATA: begin
          w_cnt_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_shreg_nxt = {w_rxs, r_shreg[DATA_W-1:1]};
            w_idx_nxt   = r_bit_idx + c_IDX_W'(1);
            if (r_bit_idx == c_IDX_W'(DATA_W-1)) begin
              w_state_nxt = S_STOP;
              w_cnt_nxt   = 4'd0;
            end
          end
        end
        S_STOP: begin
          w_cnt_nxt = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            if (w_rxs) begin
              w_stop_ok   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_stop_bad  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // A held-low line parks here so it cannot look like a new start bit
          if (w_rxs) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_cnt_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_shreg    <= w_shreg_nxt;
    end
  end

  // Delivery lands one clock after the stop sample; a pending unread byte is overwritten
  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_deliver    <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      r_deliver    <= w_stop_ok;
      rx_frame_err <= w_stop_bad;
      if (r_deliver) begin
        rx_data    <= r_shreg;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid && !rx_ready;
      end else begin
        rx_overrun <= 1'b0;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. The receiver is built 4x
//                faster (bit = 217 clocks) to keep run time short; the scenarios
//                scale the glitch, break and tolerance timings to match.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  localparam int c_OVS_INC = 19328 * 4;
  localparam int c_BIT     = 217;
  localparam int c_FAST    = 213;
  localparam int c_SLOW    = 221;

  logic       clock100;
  logic       reset_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx #(.ACC_W(20), .OVS_INC(c_OVS_INC), .DATA_W(8)) dut (
    .clock100    (clock100),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun)
  );

  initial clock100 = 1'b0;
  always #5 clock100 = ~clock100;

  int n_tests = 0;
  int n_fail  = 0;

  // Observed traffic
  logic [7:0] got_q[$];
  int         n_ferr = 0;
  int         n_ovr  = 0;

  // Reference model: bytes the consumer should see, plus expected error counts
  logic [7:0] exp_q[$];
  int         m_ferr = 0;
  int         m_ovr  = 0;
  logic       m_pending = 1'b0;
  logic [7:0] m_data = 8'h00;

  always @(negedge clock100) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_frame_err) n_ferr++;
      if (rx_overrun) n_ovr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock100);
    #2;
  endtask

  // One 8N1 frame; the model decides what the consumer should observe
  task automatic send(input logic [7:0] b, input int per, input logic stop);
    hold(1'b0, per);
    for (int i = 0; i < 8; i++) hold(b[i], per);
    hold(stop, per);
    if (!stop) begin
      m_ferr++;
    end else if (rx_ready) begin
      exp_q.push_back(b);
    end else begin
      if (m_pending) m_ovr++;
      m_pending = 1'b1;
      m_data    = b;
    end
  endtask

  task automatic check_traffic(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      check({tag, "_byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD_BEEF, {24'h0, exp_q[i]});
    check({tag, "_ferr"}, n_ferr, m_ferr);
    check({tag, "_ovr"}, n_ovr, m_ovr);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         per;

    reset_n  = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    #23;
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    @(posedge clock100); #2;
    reset_n = 1'b1;
    hold(1'b1, 100);

    // T1: plain byte
    send(8'h40, c_BIT, 1'b1);
    hold(1'b1, 300);
    check_traffic("t1");

    // T2: short low glitch, then a normal frame proves the FSM is back in IDLE
    hold(1'b0, 50);
    hold(1'b1, 600);
    check_traffic("t2_glitch");
    send(8'hC3, c_BIT, 1'b1);
    hold(1'b1, 300);
    check_traffic("t2_after");

    // T3: framing error followed by a long break, then a good frame
    send(8'h5A, c_BIT, 1'b0);
    hold(1'b0, 750);
    hold(1'b1, 100);
    send(8'hA5, c_BIT, 1'b1);
    hold(1'b1, 300);
    check_traffic("t3");

    // T4: two frames back to back with the consumer stalled
    rx_ready = 1'b0;
    send(8'h55, c_BIT, 1'b1);
    send(8'hAA, c_BIT, 1'b1);
    hold(1'b1, 300);
    check("t4_valid_held", rx_valid, 1);
    check("t4_data", rx_data, 32'hAA);
    rx_ready = 1'b1;
    @(negedge clock100);
    check("t4_valid_before_hs", rx_valid, 1);
    exp_q.push_back(m_data);
    m_pending = 1'b0;
    @(negedge clock100);
    check("t4_valid_after_hs", rx_valid, 0);
    #1;
    check_traffic("t4");

    // T5: reset in the middle of data bit 3 with an unread byte pending
    rx_ready = 1'b0;
    b = 8'($urandom_range(1, 255));
    send(b, c_BIT, 1'b1);
    hold(1'b1, 50);
    check("t5_pending", rx_valid, 1);
    b = 8'($urandom);
    hold(1'b0, c_BIT);
    for (int i = 0; i < 3; i++) hold(b[i], c_BIT);
    hold(b[3], 100);
    reset_n = 1'b0;
    #1;
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_data", rx_data, 0);
    check("t5_rst_ferr", rx_frame_err, 0);
    check("t5_rst_ovr", rx_overrun, 0);
    m_pending = 1'b0;
    hold(1'b1, 5);
    reset_n  = 1'b1;
    rx_ready = 1'b1;
    hold(1'b1, 300);
    send(8'h3C, c_BIT, 1'b1);
    hold(1'b1, 300);
    check_traffic("t5");

    // T6: baud tolerance at both extremes
    send(8'hFF, c_FAST, 1'b1);
    send(8'h00, c_SLOW, 1'b1);
    send(8'hFF, c_SLOW, 1'b1);
    send(8'h00, c_FAST, 1'b1);
    hold(1'b1, 300);
    check_traffic("t6");

    // Random bytes, random baud within tolerance, random gaps including none
    for (int k = 0; k < 10; k++) begin
      per = int'($urandom_range(c_FAST, c_SLOW));
      send(8'($urandom), per, 1'b1);
      if ($urandom_range(0, 1) == 1) hold(1'b1, int'($urandom_range(1, 40)));
    end
    hold(1'b1, 300);
    check_traffic("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
